pipe_stage_em: RTL
==================

# pipe_stage_em

Parametrised execute-to-memory pipeline stage register with a valid/ready handshake, a one-entry skid buffer, flush and bubble accounting. It sits between the execute stage and the memory stage of the RISC-V pipeline. It replaces the fixed always-load stage register with one that supports back-pressure from the memory stage and squashes from the hazard unit. Bubbles are guaranteed never to write the register file or memory.

## Interface
- XLEN, 32, width of ALU result, store data and PC+4
- REG_ADDR_W, 5, destination register index width
- RESULT_SRC_W, 2, width of result-select control field
- CNT_W, 32, width of bubble counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  hazard-unit squash of all held entries
- valid_e  in  1  execute stage presents an instruction
- ready_e  out  1  stage can accept this cycle
- RegWriteE  in  1  register-file write enable
- ResultSrcE  in  RESULT_SRC_W  writeback result select
- MemWriteE  in  1  data-memory write enable
- ALUResultE  in  XLEN  ALU result / memory address
- WriteDataE  in  XLEN  store data
- RdE  in  REG_ADDR_W  destination register
- PCPlus4E  in  XLEN  PC+4
- valid_m  out  1  memory stage holds a valid instruction
- ready_m  in  1  memory stage consumes this cycle
- RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M  out  widths as E counterparts  registered payload
- occupancy  out  2  entries held, 0..2
- bubble_cnt  out  CNT_W  saturating count of bubble cycles

## Operation
- Two entries: main (drives M outputs) and skid. Invariant: skid valid implies main valid.
- ready_e = ~skid_valid, from state only; no combinational path from ready_m or valid_e.
- valid_m = main_valid. occupancy = main_valid + skid_valid.
- in_fire = valid_e & ready_e; out_fire = valid_m & ready_m.
- Update when flush=0:
  - main empty: in_fire -> main <= E payload, main_valid <= 1.
  - main full, skid empty: out_fire & in_fire -> main <= E payload; out_fire only -> main_valid <= 0; in_fire only -> skid <= E payload, skid_valid <= 1; neither -> hold.
  - main full, skid full: out_fire -> main <= skid, skid_valid <= 0; else hold.
- flush=1: main_valid, skid_valid <= 0; E payload discarded even if valid_e=1; flush beats every other update. Payload data registers not cleared.
- Bubble safety: RegWriteM = main_valid & main.RegWrite; MemWriteM = main_valid & main.MemWrite. Other M fields show held payload regardless of valid.
- bubble_cnt increments by 1 on each edge where valid_m=0 (including flushed and reset-exit cycles, excluding the reset edge); saturates at 2^CNT_W-1, never wraps.
- rst=1: both valid bits 0, all payload registers 0, bubble_cnt 0; overrides flush and handshakes.

## Timing
- Reset values: ready_e=1, valid_m=0, all M payload outputs 0, occupancy=0, bubble_cnt=0.
- Latency: instruction accepted at edge N appears at valid_m/outputs after edge N (1 cycle) when stage was empty or draining.
- Throughput: 1 instruction/cycle with ready_m held high; skid never used then.
- ready_m low for one cycle while full: incoming instruction goes to skid; ready_e falls after that edge; order preserved (FIFO).
- Simultaneous flush and out_fire: downstream sees the transfer in that cycle; after edge stage is empty.
- Reset mid-operation: held entries dropped at that edge; no write enables asserted on M outputs during or after.

## Test plan
- Reset: assert rst 2 cycles with valid_e=1 -> valid_m=0, RegWriteM=0, occupancy=0, ready_e=1, bubble_cnt=0; first edge after release with nothing held -> bubble_cnt=1.
- Streaming: ready_m=1, send Rd=1..8, ALUResult=0x100+i on consecutive cycles -> each appears exactly 1 cycle later, in order, ready_e stays 1, occupancy≤1.
- Back-pressure: drop ready_m for 3 cycles mid-stream -> occupancy reaches 2, ready_e=0, no instruction lost or duplicated; Rd order on M intact after ready_m returns.
- Flush: occupancy=2 with RegWrite=1, MemWrite=1 entries, pulse flush with valid_e=1 -> next cycle valid_m=0, RegWriteM=0, MemWriteM=0, occupancy=0, flushed-cycle input absent from output.
- Bubble gating: valid_e carries RegWriteE=1 but is flushed -> RegWriteM never 1; held ALUResultM value unchanged.
- Saturation: CNT_W=4, hold valid_e=0 for 20 cycles -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_em.sv
// rtl/pipe_stage_em.sv - execute-to-memory stage register with skid buffer, flush and bubble counter
module pipe_stage_em #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RESULT_SRC_W = 2,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    valid_e,
    output logic                    ready_e,
    input  logic                    RegWriteE,
    input  logic [RESULT_SRC_W-1:0] ResultSrcE,
    input  logic                    MemWriteE,
    input  logic [XLEN-1:0]         ALUResultE,
    input  logic [XLEN-1:0]         WriteDataE,
    input  logic [REG_ADDR_W-1:0]   RdE,
    input  logic [XLEN-1:0]         PCPlus4E,
    output logic                    valid_m,
    input  logic                    ready_m,
    output logic                    RegWriteM,
    output logic [RESULT_SRC_W-1:0] ResultSrcM,
    output logic                    MemWriteM,
    output logic [XLEN-1:0]         ALUResultM,
    output logic [XLEN-1:0]         WriteDataM,
    output logic [REG_ADDR_W-1:0]   RdM,
    output logic [XLEN-1:0]         PCPlus4M,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        bubble_cnt
);

    typedef struct packed {
        logic                    regWrite;
        logic [RESULT_SRC_W-1:0] resultSrc;
        logic                    memWrite;
        logic [XLEN-1:0]         aluResult;
        logic [XLEN-1:0]         writeData;
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN-1:0]         pcPlus4;
    } payload_t;

    payload_t         inPayload;
    payload_t         mainEntry;
    payload_t         skidEntry;
    logic             mainValid;
    logic             skidValid;
    logic             inFire;
    logic             outFire;
    logic [CNT_W-1:0] bubbleCnt;

    always_comb begin
        inPayload.regWrite  = RegWriteE;
        inPayload.resultSrc = ResultSrcE;
        inPayload.memWrite  = MemWriteE;
        inPayload.aluResult = ALUResultE;
        inPayload.writeData = WriteDataE;
        inPayload.rd        = RdE;
        inPayload.pcPlus4   = PCPlus4E;
    end

    // ready_e depends only on held state, so no combinational path crosses the stage
    assign ready_e = ~skidValid;
    assign valid_m = mainValid;
    assign inFire  = valid_e & ready_e;
    assign outFire = mainValid & ready_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainEntry <= '0;
            skidEntry <= '0;
            bubbleCnt <= '0;
        end else begin
            if (!mainValid && bubbleCnt != '1)
                bubbleCnt <= bubbleCnt + CNT_W'(1);

            if (flush) begin
                mainValid <= 1'b0;
                skidValid <= 1'b0;
            end else if (!mainValid) begin
                if (inFire) begin
                    mainEntry <= inPayload;
                    mainValid <= 1'b1;
                end
            end else if (!skidValid) begin
                if (outFire && inFire) begin
                    mainEntry <= inPayload;
                end else if (outFire) begin
                    mainValid <= 1'b0;
                end else if (inFire) begin
                    skidEntry <= inPayload;
                    skidValid <= 1'b1;
                end
            end else if (outFire) begin
                mainEntry <= skidEntry;
                skidValid <= 1'b0;
            end
        end
    end

    // Write enables are gated so a bubble can never commit state downstream
    assign RegWriteM  = mainValid & mainEntry.regWrite;
    assign MemWriteM  = mainValid & mainEntry.memWrite;
    assign ResultSrcM = mainEntry.resultSrc;
    assign ALUResultM = mainEntry.aluResult;
    assign WriteDataM = mainEntry.writeData;
    assign RdM        = mainEntry.rd;
    assign PCPlus4M   = mainEntry.pcPlus4;
    assign occupancy  = {1'b0, mainValid} + {1'b0, skidValid};
    assign bubble_cnt = bubbleCnt;

endmodule
